// File: rtl/sprite_region_fill.sv
// Rasters an SPR_W x SPR_H rectangle of a single pixel value onto a framebuffer
// write port, one pixel per cycle, suppressing writes that fall off-screen.
module sprite_region_fill #(
   parameter int unsigned SPR_W    = 16,
   parameter int unsigned SPR_H    = 16,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned SCREEN_W = 640,
   parameter int unsigned SCREEN_H = 480,
   parameter int unsigned COORD_W  = 10
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic [DATA_W-1:0]  fill_data,
   output logic               busy,
   output logic               done,
   output logic [DATA_W-1:0]  data_out,
   output logic [COORD_W-1:0] x_out,
   output logic [COORD_W-1:0] y_out,
   output logic               write_enable
);

   localparam int unsigned COL_W = $clog2(SPR_W + 1);
   localparam int unsigned ROW_W = $clog2(SPR_H + 1);
   localparam int unsigned SUM_W = COORD_W + 1;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPR_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SPR_H - 1);
   localparam logic [SUM_W-1:0] X_LIMIT  = SUM_W'(SCREEN_W);
   localparam logic [SUM_W-1:0] Y_LIMIT  = SUM_W'(SCREEN_H);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [COL_W-1:0]   col_q, col_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [COORD_W-1:0] x0_q, x0_d;
   logic [COORD_W-1:0] y0_q, y0_d;
   logic [DATA_W-1:0]  pix_q, pix_d;

   logic               busy_d;
   logic               done_d;
   logic [DATA_W-1:0]  data_out_d;
   logic [COORD_W-1:0] x_out_d;
   logic [COORD_W-1:0] y_out_d;
   logic               in_bounds_q, in_bounds_d;
   logic [SUM_W-1:0]   x_sum;
   logic [SUM_W-1:0]   y_sum;

   // Next state, raster counters, and the pixel to present in the following cycle
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      x0_d        = x0_q;
      y0_d        = y0_q;
      pix_d       = pix_q;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      data_out_d  = '0;
      x_out_d     = '0;
      y_out_d     = '0;
      in_bounds_d = 1'b0;
      x_sum       = '0;
      y_sum       = '0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FILL;
               x0_d    = x;
               y0_d    = y;
               pix_d   = fill_data;
               col_d   = '0;
               row_d   = '0;
            end
         end
         FILL: begin
            if (abort) begin
               state_d = IDLE;
               col_d   = '0;
               row_d   = '0;
            end else if (col_q == COL_LAST) begin
               col_d = '0;
               if (row_q == ROW_LAST) begin
                  state_d = DONE;
                  row_d   = '0;
               end else begin
                  row_d = row_q + ROW_W'(1);
               end
            end else begin
               col_d = col_q + COL_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Sums carry one extra bit so off-screen wrap never aliases back on-screen
      x_sum = SUM_W'(x0_d) + SUM_W'(col_d);
      y_sum = SUM_W'(y0_d) + SUM_W'(row_d);

      if (state_d == FILL) begin
         busy_d      = 1'b1;
         x_out_d     = x_sum[COORD_W-1:0];
         y_out_d     = y_sum[COORD_W-1:0];
         data_out_d  = pix_d;
         in_bounds_d = (x_sum < X_LIMIT) && (y_sum < Y_LIMIT);
      end

      done_d = (state_d == DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Latched request, counters and registered write-port outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         col_q       <= '0;
         row_q       <= '0;
         x0_q        <= '0;
         y0_q        <= '0;
         pix_q       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         data_out    <= '0;
         x_out       <= '0;
         y_out       <= '0;
         in_bounds_q <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         x0_q        <= x0_d;
         y0_q        <= y0_d;
         pix_q       <= pix_d;
         busy        <= busy_d;
         done        <= done_d;
         data_out    <= data_out_d;
         x_out       <= x_out_d;
         y_out       <= y_out_d;
         in_bounds_q <= in_bounds_d;
      end
   end

   // An abort kills the write in the very cycle it is raised
   assign write_enable = in_bounds_q & ~abort;

endmodule
